// File: rtl/imem_program_loader_if.sv
// Byte-stream handshake between a program byte source (UART, testbench)
// and the instruction memory loader. A byte moves when valid && ready.
interface imem_program_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready
    );
endinterface

// File: rtl/imem_program_loader.sv
// Instruction memory program loader: assembles little-endian bytes into
// 32-bit words and writes them to imem addresses 0..len-1. While loading,
// the loader owns the imem address/write port and stalls the core; when
// idle, the imem address follows the core fetch address.
module imem_program_loader #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [AW:0]           len,
    imem_program_loader_if.slave  src,
    input  logic [AW-1:0]         core_addr,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_we,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  core_stall,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t           state;
    state_t           state_n;
    logic [AW:0]      word_cnt;
    logic [AW:0]      len_q;
    logic [1:0]       byte_idx;
    logic [WIDTH-1:0] buffer;
    logic             err_q;

    logic ready;
    logic xfer;
    logic len_ok;
    logic last_word;

    assign ready          = (state == S_RECV);
    assign src.byte_ready = ready;
    assign xfer           = src.byte_valid && ready;
    assign len_ok         = (len != '0) && (len <= DEPTH_L);
    assign last_word      = (word_cnt == (len_q - 1'b1));

    assign mem_wdata  = buffer;
    assign core_stall = (state != S_IDLE);
    assign busy       = core_stall;
    assign err        = err_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and imem port / status outputs.
    always_comb begin
        state_n  = state;
        mem_we   = 1'b0;
        mem_addr = word_cnt[AW-1:0];
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                mem_addr = core_addr;
                if (start && len_ok) begin
                    state_n = S_RECV;
                end
            end
            S_RECV: begin
                if (xfer && (byte_idx == 2'd3)) begin
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we  = 1'b1;
                state_n = last_word ? S_DONE : S_RECV;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Load bookkeeping: length latch, word/byte counters, word assembly, err pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
            buffer   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state == S_IDLE) && start && !len_ok;
            case (state)
                S_IDLE: begin
                    if (start && len_ok) begin
                        len_q    <= len;
                        word_cnt <= '0;
                        byte_idx <= '0;
                    end
                end
                S_RECV: begin
                    if (xfer) begin
                        buffer[{byte_idx, 3'b000} +: 8] <= src.byte_data;
                        byte_idx                        <= byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    if (!last_word) begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: random byte streams with
// random valid gaps, checked against a word-level reference built from the
// byte list (word i = bytes 4i..4i+3, little-endian, written to address i).
module tb_imem_program_loader;
    localparam int DEPTH = 256;
    localparam int WIDTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [AW:0]      len;
    logic [AW-1:0]    core_addr;
    logic [AW-1:0]    mem_addr;
    logic             mem_we;
    logic [WIDTH-1:0] mem_wdata;
    logic             core_stall;
    logic             busy;
    logic             done;
    logic             err;

    imem_program_loader_if src_if();

    always #5 clk = ~clk;

    imem_program_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .src        (src_if),
        .core_addr  (core_addr),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .core_stall (core_stall),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic [7:0]  prog[$];
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int i);
        return {prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]};
    endfunction

    task automatic fill_prog(input int n);
        prog.delete();
        for (int i = 0; i < 4*n; i++) prog.push_back(8'($urandom));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record every imem write and check per-cycle invariants.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mem_we) begin
                wr_addr_q.push_back(int'(mem_addr));
                wr_data_q.push_back(mem_wdata);
                wr_cyc_q.push_back(cyc);
                check("ready_in_write", 64'(src_if.byte_ready), 64'(0));
            end
            if (done) check("ready_in_done", 64'(src_if.byte_ready), 64'(0));
            check("done_err_excl", 64'(done & err), 64'(0));
            check("busy_eq_stall", 64'(busy), 64'(core_stall));
        end
    end

    task automatic run_load(input int n, input int pct, input int abort_at, input bit inject);
        int base;
        int sent;
        int start_cyc;
        int budget;
        int nw;
        bit got_done;
        bit aborted;
        bit xfer;
        base     = wr_addr_q.size();
        sent     = 0;
        got_done = 1'b0;
        aborted  = 1'b0;
        xfer     = 1'b0;
        budget   = 40*n + 100;
        @(posedge clk); #1;
        start     = 1'b1;
        len       = (AW+1)'(n);
        start_cyc = cyc;
        while (!got_done && !aborted && budget > 0) begin
            @(negedge clk);
            xfer = src_if.byte_valid && src_if.byte_ready;
            @(posedge clk); #1;
            budget--;
            if (xfer) sent++;
            if (inject && sent == 2) begin
                start = 1'b1;
                len   = (AW+1)'(1);
            end else begin
                start = 1'b0;
            end
            core_addr = AW'($urandom);
            if (done) begin
                got_done = 1'b1;
                if (pct == 100) check("done_latency", 64'(cyc - start_cyc), 64'(5*n + 1));
            end else if (abort_at >= 0 && sent == abort_at) begin
                rst_n   = 1'b0;
                aborted = 1'b1;
            end
            src_if.byte_valid = (sent < 4*n) && (int'($urandom_range(99)) < pct);
            src_if.byte_data  = src_if.byte_valid ? prog[sent] : 8'($urandom);
        end
        src_if.byte_valid = 1'b0;
        start = 1'b0;
        if (aborted) begin
            #1;
            check("rst_ready", 64'(src_if.byte_ready), 64'(0));
            check("rst_we", 64'(mem_we), 64'(0));
            check("rst_stall", 64'(core_stall), 64'(0));
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_done", 64'(done), 64'(0));
            check("rst_err", 64'(err), 64'(0));
            check("rst_addr_mux", 64'(mem_addr), 64'(core_addr));
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            nw = abort_at / 4;
        end else begin
            check("done_seen", 64'(got_done), 64'(1));
            @(posedge clk); #1;
            check("done_pulse", 64'(done), 64'(0));
            check("stall_after", 64'(core_stall), 64'(0));
            check("idle_addr_mux", 64'(mem_addr), 64'(core_addr));
            nw = n;
        end
        check("write_count", 64'(wr_addr_q.size() - base), 64'(nw));
        for (int i = 0; i < nw && base + i < wr_addr_q.size(); i++) begin
            check("write_addr", 64'(wr_addr_q[base+i]), 64'(i));
            check("write_data", 64'(wr_data_q[base+i]), 64'(model_word(i)));
            if (pct == 100 && i > 0)
                check("write_spacing", 64'(wr_cyc_q[base+i] - wr_cyc_q[base+i-1]), 64'(5));
        end
    endtask

    task automatic bad_start(input int l);
        int base;
        base = wr_addr_q.size();
        @(posedge clk); #1;
        start = 1'b1;
        len   = (AW+1)'(l);
        @(posedge clk); #1;
        start = 1'b0;
        check("err_pulse", 64'(err), 64'(1));
        check("err_not_busy", 64'(busy), 64'(0));
        check("err_no_done", 64'(done), 64'(0));
        @(posedge clk); #1;
        check("err_one_cycle", 64'(err), 64'(0));
        check("err_still_idle", 64'(core_stall), 64'(0));
        check("err_no_write", 64'(wr_addr_q.size() - base), 64'(0));
    endtask

    initial begin
        rst_n             = 1'b0;
        start             = 1'b0;
        len               = '0;
        core_addr         = AW'($urandom);
        src_if.byte_valid = 1'b0;
        src_if.byte_data  = '0;
        #2;
        check("reset_ready", 64'(src_if.byte_ready), 64'(0));
        check("reset_we", 64'(mem_we), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_err", 64'(err), 64'(0));
        check("reset_stall", 64'(core_stall), 64'(0));
        check("reset_addr_mux", 64'(mem_addr), 64'(core_addr));
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Single known instruction word.
        prog.delete();
        prog.push_back(8'h93);
        prog.push_back(8'h00);
        prog.push_back(8'h70);
        prog.push_back(8'h00);
        run_load(1, 100, -1, 1'b0);
        if (wr_data_q.size() > 0)
            check("t1_wdata", 64'(wr_data_q[wr_data_q.size()-1]), 64'(32'h00700093));

        // Three words back-to-back, then same program with random gaps.
        fill_prog(3);
        run_load(3, 100, -1, 1'b0);
        run_load(3, 50, -1, 1'b0);

        // Rejected lengths.
        bad_start(0);
        bad_start(DEPTH + 1);

        // Reset after six bytes of a two-word load.
        fill_prog(2);
        run_load(2, 100, 6, 1'b0);

        // Start pulsed mid-load must be ignored.
        fill_prog(2);
        run_load(2, 80, -1, 1'b1);

        // Random short loads with random gaps.
        repeat (4) begin
            int n;
            n = int'($urandom_range(6, 1));
            fill_prog(n);
            run_load(n, 70, -1, 1'b0);
        end

        // Full-depth load.
        fill_prog(DEPTH);
        run_load(DEPTH, 100, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
